// File: rtl/cpu_sram_arbiter.sv
// Bridges the core's instruction and data SRAM ports onto one req/addr_ok/data_ok memory port.
// Data accesses win over fetches; results are buffered and released to the core in one cycle.
module cpu_sram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_for_mem,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D_REQ   = 3'd1,
    D_WAIT  = 3'd2,
    I_REQ   = 3'd3,
    I_WAIT  = 3'd4,
    RELEASE = 3'd5
  } state_t;

  typedef struct packed {
    logic [SW-1:0] wstrb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_cmd_t;

  state_t        state;
  state_t        next_state;
  logic          req_nxt;
  mem_cmd_t      cmd_nxt;
  mem_cmd_t      cmd_q;
  logic [DW-1:0] inst_buf;
  logic [DW-1:0] data_buf;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, plus the request fields to present while in the next state
  always_comb begin
    next_state = state;
    req_nxt    = 1'b0;
    cmd_nxt    = '0;
    case (state)
      IDLE: begin
        if (data_sram_en) begin
          next_state = D_REQ;
        end else if (inst_sram_en) begin
          next_state = I_REQ;
        end
      end
      D_REQ:   if (mem_addr_ok) next_state = D_WAIT;
      D_WAIT:  if (mem_data_ok) next_state = inst_sram_en ? I_REQ : RELEASE;
      I_REQ:   if (mem_addr_ok) next_state = I_WAIT;
      I_WAIT:  if (mem_data_ok) next_state = RELEASE;
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase

    // Ports are held stable while stalled, so re-sampling them keeps the request constant
    case (next_state)
      D_REQ: begin
        req_nxt = 1'b1;
        cmd_nxt = '{wstrb: data_sram_wen, addr: data_sram_addr, wdata: data_sram_wdata};
      end
      I_REQ: begin
        req_nxt = 1'b1;
        cmd_nxt = '{wstrb: inst_sram_wen, addr: inst_sram_addr, wdata: inst_sram_wdata};
      end
      default: begin
        req_nxt = 1'b0;
        cmd_nxt = '0;
      end
    endcase
  end

  // Registered memory-side request and response buffers
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req  <= 1'b0;
      mem_wr   <= 1'b0;
      cmd_q    <= '0;
      inst_buf <= '0;
      data_buf <= '0;
    end else begin
      mem_req <= req_nxt;
      mem_wr  <= |cmd_nxt.wstrb;
      cmd_q   <= cmd_nxt;
      if (state == D_WAIT && mem_data_ok) begin
        data_buf <= (|data_sram_wen) ? DW'(0) : mem_rdata;
      end
      if (state == I_WAIT && mem_data_ok) begin
        inst_buf <= (|inst_sram_wen) ? DW'(0) : mem_rdata;
      end
    end
  end

  assign mem_wstrb       = cmd_q.wstrb;
  assign mem_addr        = cmd_q.addr;
  assign mem_wdata       = cmd_q.wdata;
  assign inst_sram_rdata = inst_buf;
  assign data_sram_rdata = data_buf;

  // Stall is combinational so the pipeline freezes in the very cycle a request appears
  assign stallreq_for_mem = (inst_sram_en | data_sram_en) & (state != RELEASE);

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Self-checking bench for cpu_sram_arbiter: directed table, reset corner cases and
// randomized transactions checked against a transaction-level model.
`timescale 1ns/1ps
module tb_cpu_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_for_mem;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  cpu_sram_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .inst_sram_en     (inst_sram_en),
    .inst_sram_wen    (inst_sram_wen),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_wdata  (inst_sram_wdata),
    .inst_sram_rdata  (inst_sram_rdata),
    .data_sram_en     (data_sram_en),
    .data_sram_wen    (data_sram_wen),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .data_sram_rdata  (data_sram_rdata),
    .stallreq_for_mem (stallreq_for_mem),
    .mem_req          (mem_req),
    .mem_wr           (mem_wr),
    .mem_wstrb        (mem_wstrb),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_addr_ok      (mem_addr_ok),
    .mem_data_ok      (mem_data_ok),
    .mem_rdata        (mem_rdata)
  );

  typedef struct {
    logic        d_en;
    logic [3:0]  d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_ret;
    int          d_ad;
    int          d_dd;
    logic        i_en;
    logic [3:0]  i_wen;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [31:0] i_ret;
    int          i_ad;
    int          i_dd;
  } txn_t;

  typedef struct {
    txn_t        t;
    int          exp_stall;
    logic [31:0] exp_d;
    logic [31:0] exp_i;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ret;
    logic [3:0]  wstrb;
    int          ad;
    int          dd;
  } acc_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] model_dbuf = 32'h0;
  logic [31:0] model_ibuf = 32'h0;
  vec_t        tbl[6];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic txn_t mkt(input logic d_en, input logic [3:0] d_wen, input logic [31:0] d_addr,
                               input logic [31:0] d_wdata, input logic [31:0] d_ret, input int d_ad,
                               input int d_dd, input logic i_en, input logic [31:0] i_addr,
                               input logic [31:0] i_ret, input int i_ad, input int i_dd);
    txn_t t;
    t.d_en = d_en; t.d_wen = d_wen; t.d_addr = d_addr; t.d_wdata = d_wdata; t.d_ret = d_ret;
    t.d_ad = d_ad; t.d_dd = d_dd;
    t.i_en = i_en; t.i_wen = 4'h0; t.i_addr = i_addr; t.i_wdata = 32'h0; t.i_ret = i_ret;
    t.i_ad = i_ad; t.i_dd = i_dd;
    return t;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; inst_sram_en = 1'b0; data_sram_en = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_dbuf = 32'h0;
    model_ibuf = 32'h0;
  endtask

  // Plays the core (holding its request) and the memory (with per-access latencies)
  task automatic run_txn(input txn_t t, input int exp_stall, input logic [31:0] exp_d,
                         input logic [31:0] exp_i);
    acc_t q[$];
    acc_t a;
    int   k = 0, phase = 0, rc = 0, wc = 0, stalls = 0;
    bit   done = 0, timed_out = 0;
    if (t.d_en) begin
      a.addr = t.d_addr; a.wdata = t.d_wdata; a.ret = t.d_ret; a.wstrb = t.d_wen;
      a.ad = t.d_ad; a.dd = t.d_dd;
      q.push_back(a);
    end
    if (t.i_en) begin
      a.addr = t.i_addr; a.wdata = t.i_wdata; a.ret = t.i_ret; a.wstrb = t.i_wen;
      a.ad = t.i_ad; a.dd = t.i_dd;
      q.push_back(a);
    end
    @(negedge clk);
    data_sram_en = t.d_en; data_sram_wen = t.d_wen; data_sram_addr = t.d_addr;
    data_sram_wdata = t.d_wdata;
    inst_sram_en = t.i_en; inst_sram_wen = t.i_wen; inst_sram_addr = t.i_addr;
    inst_sram_wdata = t.i_wdata;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    while (!done) begin
      #1;
      if (!stallreq_for_mem) begin
        done = 1;
      end else if (stalls >= 100) begin
        n_vec++; n_bad++;
        $display("FAIL stall_timeout: still stalled after %0d cycles, expected %0d", stalls, exp_stall);
        done = 1; timed_out = 1;
      end else begin
        stalls++;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = $urandom;
        if (mem_req) begin
          if (phase != 0 || k >= q.size()) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_req: mem_req=1 at stall cycle %0d, expected 0", stalls);
          end else begin
            check32("req_addr", mem_addr, q[k].addr);
            check32("req_wdata", mem_wdata, q[k].wdata);
            check32("req_wstrb", 32'(mem_wstrb), 32'(q[k].wstrb));
            check32("req_wr", 32'(mem_wr), 32'(q[k].wstrb != 4'h0));
            if (rc == q[k].ad) begin
              mem_addr_ok = 1'b1; phase = 1; rc = 0; wc = 0;
            end else begin
              rc++;
            end
          end
        end else begin
          check32("idle_fields", mem_addr | mem_wdata | 32'(mem_wstrb) | 32'(mem_wr), 32'h0);
          if (phase == 1) begin
            if (wc == q[k].dd) begin
              mem_data_ok = 1'b1; mem_rdata = q[k].ret; k++; phase = 0;
            end else begin
              wc++;
              mem_addr_ok = 1'($urandom_range(0, 3) == 0);
            end
          end
        end
        @(negedge clk);
      end
    end
    // Keep data_ok high with fresh garbage through RELEASE; it must not be captured
    mem_rdata = $urandom;
    if (timed_out) begin
      do_reset();
    end else begin
      check32("stall_cycles", 32'(stalls), 32'(exp_stall));
      check32("accesses_done", 32'(k), 32'(q.size()));
      check32("data_rdata", data_sram_rdata, exp_d);
      check32("inst_rdata", inst_sram_rdata, exp_i);
      check32("release_req", 32'(mem_req), 32'h0);
      model_dbuf = exp_d;
      model_ibuf = exp_i;
    end
  endtask

  initial begin
    // Reset with random inputs for two cycles
    rst = 1'b0;
    inst_sram_en = 1'($urandom); inst_sram_wen = 4'($urandom); inst_sram_addr = $urandom;
    inst_sram_wdata = $urandom;
    data_sram_en = 1'($urandom); data_sram_wen = 4'($urandom); data_sram_addr = $urandom;
    data_sram_wdata = $urandom;
    mem_addr_ok = 1'($urandom); mem_data_ok = 1'($urandom); mem_rdata = $urandom;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check32("rst_mem_req", 32'(mem_req), 32'h0);
    check32("rst_mem_fields", mem_addr | mem_wdata | 32'(mem_wstrb) | 32'(mem_wr), 32'h0);
    check32("rst_data_rdata", data_sram_rdata, 32'h0);
    check32("rst_inst_rdata", inst_sram_rdata, 32'h0);
    rst = 1'b1; inst_sram_en = 1'b0; data_sram_en = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    #1;
    check32("rst_idle_stall", 32'(stallreq_for_mem), 32'h0);

    // Directed table: data(en,wen,addr,wdata,ret,ad,dd), inst(en,addr,ret,ad,dd)
    tbl[0].t = mkt(0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'hBFC00000, 32'h3C08BFAF, 0, 0);
    tbl[0].exp_stall = 3; tbl[0].exp_d = 32'h0;        tbl[0].exp_i = 32'h3C08BFAF;
    tbl[1].t = mkt(1, 4'h0, 32'h80001000, 32'h0, 32'h12345678, 0, 0, 1, 32'hBFC00004, 32'h0, 0, 0);
    tbl[1].exp_stall = 5; tbl[1].exp_d = 32'h12345678; tbl[1].exp_i = 32'h0;
    tbl[2].t = mkt(1, 4'b0011, 32'h80002000, 32'hAABBCCDD, 32'h55555555, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    tbl[2].exp_stall = 3; tbl[2].exp_d = 32'h0;        tbl[2].exp_i = 32'h0;
    tbl[3].t = mkt(0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'hBFC00008, 32'h24020001, 3, 0);
    tbl[3].exp_stall = 6; tbl[3].exp_d = 32'h0;        tbl[3].exp_i = 32'h24020001;
    tbl[4].t = mkt(0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    tbl[4].exp_stall = 0; tbl[4].exp_d = 32'h0;        tbl[4].exp_i = 32'h24020001;
    tbl[5].t = mkt(1, 4'h0, 32'h80004000, 32'h0, 32'hDEADBEEF, 1, 2, 0, 32'h0, 32'h0, 0, 0);
    tbl[5].exp_stall = 6; tbl[5].exp_d = 32'hDEADBEEF; tbl[5].exp_i = 32'h24020001;
    for (int v = 0; v < 6; v++) begin
      run_txn(tbl[v].t, tbl[v].exp_stall, tbl[v].exp_d, tbl[v].exp_i);
    end

    // Reset during D_WAIT, then a spurious data_ok after reset releases
    @(negedge clk);
    data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h80003000;
    inst_sram_en = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    @(negedge clk);
    check32("rmid_req", 32'(mem_req), 32'h1);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    check32("rmid_wait_req", 32'(mem_req), 32'h0);
    mem_addr_ok = 1'b0; rst = 1'b0; data_sram_en = 1'b0;
    @(negedge clk);
    rst = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    check32("rmid_data_buf", data_sram_rdata, 32'h0);
    check32("rmid_inst_buf", inst_sram_rdata, 32'h0);
    check32("rmid_stall", 32'(stallreq_for_mem), 32'h0);
    @(negedge clk);
    mem_data_ok = 1'b0;
    check32("rmid_spurious_ignored", data_sram_rdata, 32'h0);
    check32("rmid_idle_req", 32'(mem_req), 32'h0);
    model_dbuf = 32'h0;
    model_ibuf = 32'h0;
    run_txn(mkt(0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'hBFC00010, 32'h8C220004, 0, 0),
            3, 32'h0, 32'h8C220004);

    // Randomized transactions against the transaction-level model
    for (int r = 0; r < 60; r++) begin
      txn_t        t;
      int          es;
      logic [31:0] ed, ei;
      t.d_en = 1'($urandom); t.d_wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      t.d_addr = $urandom; t.d_wdata = $urandom; t.d_ret = $urandom;
      t.d_ad = $urandom_range(0, 3); t.d_dd = $urandom_range(0, 3);
      t.i_en = 1'($urandom); t.i_wen = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      t.i_addr = $urandom; t.i_wdata = $urandom; t.i_ret = $urandom;
      t.i_ad = $urandom_range(0, 3); t.i_dd = $urandom_range(0, 3);
      es = 0;
      if (t.d_en || t.i_en) es = 1;
      if (t.d_en) es += t.d_ad + 1 + t.d_dd + 1;
      if (t.i_en) es += t.i_ad + 1 + t.i_dd + 1;
      ed = !t.d_en ? model_dbuf : (t.d_wen != 4'h0) ? 32'h0 : t.d_ret;
      ei = !t.i_en ? model_ibuf : (t.i_wen != 4'h0) ? 32'h0 : t.i_ret;
      run_txn(t, es, ed, ei);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
